pipe_stage_skid_reg: RTL
========================

Name: pipe_stage_skid_reg

Overview:
Generic, parametrised pipeline stage register for the 5-stage core. It replaces the hard-wired per-stage registers with a valid/ready stage that carries an opaque data payload and a control bundle. A two-entry skid buffer keeps in_ready registered, so back-pressure does not form a combinational path across stages. A flush drains the stage and presents a NOP control word.

Parameters:
DATA_W, 128, payload width (pc, operands, imm, register numbers, funct fields), bits
CTRL_W, 8, control bundle width (reg_write, alu_src, alu_op, mem_read, mem_write, mem_to_reg, branch), bits
CTRL_NOP, {CTRL_W{1'b0}}, control value presented whenever out_valid=0

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream holds a valid entry
in_ready  out  1  stage accepts input this cycle; registered
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bundle
flush  in  1  synchronous kill of all held entries
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts; low = stall
out_data  out  DATA_W  main entry payload
out_ctrl  out  CTRL_W  main entry control; CTRL_NOP when out_valid=0
occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready at a posedge.
  - Output transfer occurs when out_valid & out_ready at a posedge.
  - Upstream must not drop in_valid or change in_data/in_ctrl once presented until accepted.
- Storage: a main register (drives out_*) and a skid register.
- in_ready = !skid_valid. It comes straight from a flop, with no combinational path from out_ready.
- State machine:
  - EMPTY (occ 0):
    - in_valid -> FULL, load main.
  - FULL (occ 1):
    - out_ready & in_valid -> FULL, main <= input.
    - out_ready & !in_valid -> EMPTY.
    - !out_ready & in_valid -> SKID, skid <= input, main held.
    - !out_ready & !in_valid -> FULL, hold.
  - SKID (occ 2, in_ready=0):
    - out_ready -> FULL, main <= skid.
    - otherwise hold both entries.
- Latency:
  - 1 cycle from input transfer to out_valid when the stage is not stalled.
  - Throughput is 1 entry per cycle with out_ready held high.
- Ordering: strictly FIFO. The skid entry is never bypassed by a newer input.
- out_ctrl:
  - Registered.
  - Equals CTRL_NOP on any cycle where out_valid=0, including after drain.
- out_data:
  - Holds its last value when out_valid=0; it is not cleared (power).
  - Consumers must qualify it with out_valid.
- flush (highest priority, synchronous):
  - Next state EMPTY, out_valid=0, out_ctrl=CTRL_NOP, skid discarded, in_ready=1 the following cycle.
  - An input transfer in the flush cycle is accepted and discarded.
  - An output transfer in the flush cycle still counts as taken by downstream.
- reset (async):
  - out_valid=0, out_ctrl=CTRL_NOP, out_data=0, skid cleared, occupancy=0, in_ready=1, state EMPTY.
  - Reset mid-operation drops all entries immediately, without waiting for a clock edge.
- occupancy: registered, consistent with state, never 3.

Optional Feature:
Macro PIPE_STAGE_STATS_EN.
- When defined, two extra outputs are compiled in:
  - stall_cycles[31:0]: increments each cycle out_valid & !out_ready.
  - bubble_cycles[31:0]: increments each cycle !out_valid & !flush.
- Both counters wrap at 2^32 and reset to 0 on reset. flush does not clear them.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Streaming: reset, then in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later each, occupancy stays 1, in_ready stays 1.
- Stall fill:
  - Stimulus: feed A and B with out_ready=0 from the cycle A lands.
  - Response: occupancy 1 then 2; in_ready=0 the cycle after B is accepted; out_data stays A.
  - Then out_ready=1: A is output, then B; in_ready returns to 1 after one cycle.
- Flush:
  - Stimulus: flush=1 while occupancy=2 and a third input is presented.
  - Response: next cycle out_valid=0, out_ctrl=CTRL_NOP (0x00), occupancy 0, in_ready=1; the third input never appears.
- Async reset:
  - Stimulus: assert reset between clock edges while occupancy=2 with out_ctrl=0x5A.
  - Response: out_valid=0 and out_ctrl=0x00 immediately (no clock edge), out_data=0.
- Drain NOP: single entry ctrl=0xFF, then in_valid=0 -> out_ctrl 0xFF for one cycle, then 0x00 with out_valid=0 while out_data keeps the old payload.
- Stats (PIPE_STAGE_STATS_EN): 3 stalled cycles plus 2 idle non-flush cycles -> stall_cycles=3, bubble_cycles=2. A counter preloaded to 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid_reg
// Valid/ready pipeline stage register carrying a data payload plus a control
// bundle. A second (skid) entry lets in_ready come straight from a flop, so
// downstream back-pressure never forms a combinational path to upstream.
// Flush drains the stage; out_ctrl reads CTRL_NOP whenever out_valid is low.
//
// Optional feature: define PIPE_STAGE_STATS_EN to add the stall_cycles and
// bubble_cycles performance counters.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   in_valid      in   upstream holds a valid entry
//   in_ready      out  stage accepts input this cycle (registered)
//   in_data       in   upstream payload [DATA_W]
//   in_ctrl       in   upstream control bundle [CTRL_W]
//   flush         in   synchronous kill of all held entries
//   out_valid     out  main entry valid
//   out_ready     in   downstream accepts; low = stall
//   out_data      out  main entry payload [DATA_W]; held when out_valid=0
//   out_ctrl      out  main entry control [CTRL_W]; CTRL_NOP when out_valid=0
//   occupancy     out  entries held: 0, 1 or 2
//   stall_cycles  out  (PIPE_STAGE_STATS_EN) cycles with out_valid & !out_ready
//   bubble_cycles out  (PIPE_STAGE_STATS_EN) cycles with !out_valid & !flush
// -----------------------------------------------------------------------------
module pipe_stage_skid_reg #(
    parameter int unsigned       DATA_W   = 128,
    parameter int unsigned       CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_cycles
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_out_ctrl;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              r_in_ready;
    logic [1:0]        r_occ;

    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic [CTRL_W-1:0] w_main_ctrl_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;
    logic              w_out_valid_nxt;
    logic [CTRL_W-1:0] w_out_ctrl_nxt;
    logic              w_in_ready_nxt;
    logic [1:0]        w_occ_nxt;

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_out_ctrl  <= CTRL_NOP;
            r_out_valid <= 1'b0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
            r_in_ready  <= 1'b1;
            r_occ       <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_data_nxt;
            r_out_ctrl  <= w_out_ctrl_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_occ       <= w_occ_nxt;
        end
    end

    // Next-state and next-output logic. While the stage holds an entry,
    // r_out_ctrl is the main entry's control, so it doubles as main_ctrl.
    always_comb begin
        w_state_nxt     = r_state;
        w_main_data_nxt = r_main_data;
        w_main_ctrl_nxt = r_out_ctrl;
        w_skid_data_nxt = r_skid_data;
        w_skid_ctrl_nxt = r_skid_ctrl;

        if (flush) begin
            // Payload registers keep their value; only validity is dropped.
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        w_state_nxt     = ST_FULL;
                        w_main_data_nxt = in_data;
                        w_main_ctrl_nxt = in_ctrl;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            w_main_data_nxt = in_data;
                            w_main_ctrl_nxt = in_ctrl;
                        end else begin
                            w_state_nxt = ST_EMPTY;
                        end
                    end else if (in_valid) begin
                        // Downstream stalled: park the new entry behind main.
                        w_state_nxt     = ST_SKID;
                        w_skid_data_nxt = in_data;
                        w_skid_ctrl_nxt = in_ctrl;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        w_state_nxt     = ST_FULL;
                        w_main_data_nxt = r_skid_data;
                        w_main_ctrl_nxt = r_skid_ctrl;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end

        w_out_valid_nxt = (w_state_nxt != ST_EMPTY);
        w_in_ready_nxt  = (w_state_nxt != ST_SKID);
        w_out_ctrl_nxt  = w_out_valid_nxt ? w_main_ctrl_nxt : CTRL_NOP;
        case (w_state_nxt)
            ST_FULL: w_occ_nxt = 2'd1;
            ST_SKID: w_occ_nxt = 2'd2;
            default: w_occ_nxt = 2'd0;
        endcase
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_out_ctrl;
    assign occupancy = r_occ;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_bubble_cycles;

    // Free-running wrap-around counters; flush deliberately does not clear them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles  <= 32'd0;
            r_bubble_cycles <= 32'd0;
        end else begin
            if (r_out_valid && !out_ready) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (!r_out_valid && !flush) begin
                r_bubble_cycles <= r_bubble_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign bubble_cycles = r_bubble_cycles;
`else
    // No statistics hardware in this build.
`endif

endmodule
